leaf_user_stream_endpoint: RTL

User-clock endpoint that terminates the leaf interface's interface-to-user stream and drives the user-to-interface stream back. It sits where an HLS operator normally connects and speaks the same ap_vld/ap_ack handshake on both links. Incoming words are buffered in a FIFO and replayed in frames of FRAME_LEN words, each frame followed by one appended checksum word. Its uses are loopback bring-up of a leaf and link validation.

---
 rtl/leaf_user_stream_endpoint_if.sv | 19 +
 rtl/leaf_user_stream_endpoint.sv | 78 +++++++
 2 files changed

// File: rtl/leaf_user_stream_endpoint_if.sv
// leaf_user_stream_endpoint_if: paired ap_vld/ap_ack streams between a leaf interface and a user endpoint
interface leaf_user_stream_endpoint_if #(
  parameter int PAYLOAD_BITS = 32
);
  logic [PAYLOAD_BITS-1:0] din_interface2user;
  logic                    vld_interface2user;
  logic                    ack_user2interface;
  logic [PAYLOAD_BITS-1:0] dout_user2interface;
  logic                    vld_user2interface;
  logic                    ack_interface2user;
  modport master (
    output din_interface2user, vld_interface2user, ack_interface2user,
    input  ack_user2interface, dout_user2interface, vld_user2interface
  );
  modport slave (
    input  din_interface2user, vld_interface2user, ack_interface2user,
    output ack_user2interface, dout_user2interface, vld_user2interface
  );
endinterface

// File: rtl/leaf_user_stream_endpoint.sv
// leaf_user_stream_endpoint: FIFO loopback that replays words in frames, each followed by a checksum word
module leaf_user_stream_endpoint #(
  parameter int PAYLOAD_BITS    = 32,
  parameter int FIFO_DEPTH_BITS = 4,
  parameter int FRAME_LEN       = 8,
  parameter int COUNT_BITS      = 16
) (
  input  logic                       clk_user,
  input  logic                       reset_n,
  leaf_user_stream_endpoint_if.slave s,
  output logic [FIFO_DEPTH_BITS:0]   fifo_level,
  output logic [COUNT_BITS-1:0]      frame_count
);
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] DEPTH_W = (FIFO_DEPTH_BITS+1)'(DEPTH);
  localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);
  typedef enum logic {DATA, CKSUM} state_t;
  state_t                    r_state;
  logic [PAYLOAD_BITS-1:0]   r_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] r_wptr, r_rptr;
  logic [FIFO_DEPTH_BITS:0]  r_count, w_count_next;
  logic                      r_ack;
  logic [PAYLOAD_BITS-1:0]   r_cksum, w_dout;
  logic [7:0]                r_idx;
  logic [COUNT_BITS-1:0]     r_frames;
  logic                      w_push, w_pop, w_vld, w_xfer;
  // handshake decode; head word is shown as soon as the FIFO holds it, zero when empty
  always_comb begin
    w_push       = s.vld_interface2user & r_ack;
    w_vld        = (r_state == CKSUM) | (r_count != '0);
    w_dout       = (r_state == CKSUM) ? r_cksum : (r_count != '0) ? r_mem[r_rptr] : '0;
    w_xfer       = w_vld & s.ack_interface2user;
    w_pop        = w_xfer & (r_state == DATA);
    w_count_next = r_count + {{FIFO_DEPTH_BITS{1'b0}}, w_push} - {{FIFO_DEPTH_BITS{1'b0}}, w_pop};
  end
  // storage array, written only on an accepted push
  always_ff @(posedge clk_user) begin
    if (w_push) r_mem[r_wptr] <= s.din_interface2user;
  end
  // pointers, occupancy and registered RX ack; ack already reflects fullness so a full FIFO never takes a word
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_wptr  <= r_wptr + FIFO_DEPTH_BITS'(w_push);
      r_rptr  <= r_rptr + FIFO_DEPTH_BITS'(w_pop);
      r_count <= w_count_next;
      r_ack   <= w_count_next < DEPTH_W;
    end
  end
  // TX framing: pass FRAME_LEN data words, then one checksum word
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= DATA;
      r_cksum  <= '0;
      r_idx    <= '0;
      r_frames <= '0;
    end else if (w_xfer) begin
      if (r_state == DATA) begin
        r_cksum <= r_cksum + w_dout;
        r_idx   <= (r_idx == LAST) ? 8'd0 : r_idx + 8'd1;
        r_state <= (r_idx == LAST) ? CKSUM : DATA;
      end else begin
        r_frames <= r_frames + 1'b1;
        r_cksum  <= '0;
        r_state  <= DATA;
      end
    end
  end
  assign s.ack_user2interface  = r_ack;
  assign s.vld_user2interface  = w_vld;
  assign s.dout_user2interface = w_dout;
  assign fifo_level            = r_count;
  assign frame_count           = r_frames;
endmodule
